// File: rtl/symbol_framer.sv
// rtl/symbol_framer.sv - packs a serial bit stream into symbols and frames them with a preamble
//
// Ports:
//   clk          single clock, shared with the downstream modulator
//   rst          asynchronous active-low reset
//   in_bit       serial payload bit
//   in_valid     in_bit/in_last valid
//   in_last      current bit is the last bit of the frame
//   in_ready     bit accepted when in_valid && in_ready
//   x0/x1/x2     symbol fields, {x0,x1,x2} = symbol MSB first
//   sym_strobe   high in the first cycle of each symbol slot
//   sym_active   current slot carries preamble or payload
//   underrun     sticky: a payload slot found the FIFO empty mid-frame
module symbol_framer #(
  parameter int DIM0_WIDTH         = 2,
  parameter int DIM1_WIDTH         = 2,
  parameter int DIM2_WIDTH         = 1,
  parameter int SAMPLES_PER_SYMBOL = 10,
  parameter int COUNTER_SIZE       = 4,
  parameter int FIFO_DEPTH         = 4,
  parameter int PREAMBLE_LEN       = 4,
  parameter logic [DIM0_WIDTH+DIM1_WIDTH+DIM2_WIDTH-1:0] PREAMBLE_SYM = 5'b10101,
  parameter logic [DIM0_WIDTH+DIM1_WIDTH+DIM2_WIDTH-1:0] IDLE_SYM     = 5'b00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_bit,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DIM0_WIDTH-1:0] x0,
  output logic [DIM1_WIDTH-1:0] x1,
  output logic [DIM2_WIDTH-1:0] x2,
  output logic                  sym_strobe,
  output logic                  sym_active,
  output logic                  underrun
);

  localparam int SYM_W  = DIM0_WIDTH + DIM1_WIDTH + DIM2_WIDTH;
  localparam int BCNT_W = $clog2(SYM_W);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PRE_W  = $clog2(PREAMBLE_LEN + 1);
  localparam logic [COUNTER_SIZE-1:0] CNT_MAX = COUNTER_SIZE'(SAMPLES_PER_SYMBOL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA
  } state_t;

  // slot counter
  logic [COUNTER_SIZE-1:0] cnt_q, cnt_d;
  logic                    boundary;

  // packer
  logic [SYM_W-1:0]  pack_q, pack_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [SYM_W-1:0]  push_sym;
  logic              accept, push;

  // symbol FIFO, entry = {symbol, last}
  logic [SYM_W:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              pop;
  logic [SYM_W:0]    head;

  // framing FSM and registered outputs
  state_t            state_q;
  logic [PRE_W-1:0]  pre_q;
  logic [SYM_W-1:0]  sym_q;
  logic              active_q;
  logic              underrun_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    boundary = (cnt_q == CNT_MAX);
    cnt_d    = boundary ? COUNTER_SIZE'(1) : cnt_q + COUNTER_SIZE'(1);

    in_ready = (fcnt_q < FCNT_W'(FIFO_DEPTH));
    accept   = in_valid && in_ready;

    // Bits land MSB first; positions not yet written stay zero, which is
    // exactly the zero-fill an early in_last needs.
    push_sym = pack_q;
    for (int i = 0; i < SYM_W; i++) begin
      if (i == SYM_W - 1 - int'(bcnt_q)) push_sym[i] = in_bit;
    end
    push = accept && (in_last || (bcnt_q == BCNT_W'(SYM_W - 1)));

    pack_d = pack_q;
    bcnt_d = bcnt_q;
    if (accept) begin
      if (push) begin
        pack_d = '0;
        bcnt_d = '0;
      end else begin
        pack_d = push_sym;
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end

    // Decisions use the registered count, so a push in the boundary cycle
    // is only seen at the next boundary.
    pop  = boundary && (state_q == S_DATA) && (fcnt_q != '0);
    head = mem_q[rd_ptr_q];

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= COUNTER_SIZE'(1);
      pack_q   <= '0;
      bcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      pack_q   <= pack_d;
      bcnt_q   <= bcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by fcnt_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_sym, in_last};
  end

  // Evaluated once per slot; the new symbol appears on the wrap edge and
  // is held for the whole slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      sym_q      <= '0;
      active_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else if (boundary) begin
      unique case (state_q)
        S_IDLE: begin
          sym_q    <= IDLE_SYM;
          active_q <= 1'b0;
          if (fcnt_q != '0) begin
            state_q <= S_PRE;
            pre_q   <= '0;
          end
        end
        S_PRE: begin
          sym_q    <= PREAMBLE_SYM;
          active_q <= 1'b1;
          if (pre_q == PRE_W'(PREAMBLE_LEN - 1)) state_q <= S_DATA;
          else pre_q <= pre_q + PRE_W'(1);
        end
        S_DATA: begin
          if (fcnt_q != '0) begin
            sym_q    <= head[SYM_W:1];
            active_q <= 1'b1;
            if (head[0]) state_q <= S_IDLE;
          end else begin
            sym_q      <= IDLE_SYM;
            active_q   <= 1'b0;
            underrun_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x0         = sym_q[SYM_W-1 -: DIM0_WIDTH];
  assign x1         = sym_q[DIM1_WIDTH+DIM2_WIDTH-1 -: DIM1_WIDTH];
  assign x2         = sym_q[DIM2_WIDTH-1:0];
  assign sym_strobe = (cnt_q == COUNTER_SIZE'(1));
  assign sym_active = active_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_symbol_framer.sv
// tb/tb_symbol_framer.sv - self-checking bench for symbol_framer
module tb_symbol_framer;

  localparam int SPS     = 10;
  localparam int PRE_LEN = 4;
  localparam logic [4:0] PRE_SYM = 5'b10101;

  logic       clk;
  logic       rst;
  logic       in_bit, in_valid, in_last;
  logic       in_ready;
  logic [1:0] x0, x1;
  logic [0:0] x2;
  logic       sym_strobe, sym_active, underrun;

  int n_checks = 0;
  int n_fail   = 0;

  symbol_framer dut (
    .clk        (clk),
    .rst        (rst),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .x0         (x0),
    .x1         (x1),
    .x2         (x2),
    .sym_strobe (sym_strobe),
    .sym_active (sym_active),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed slots and reference model state
  int         cyc;
  logic [4:0] slot_x;
  logic       slot_act;
  logic [4:0] slot_sym_q[$];
  logic       slot_act_q[$];
  logic [4:0] act_sym_q[$];
  logic [4:0] exp_q[$];
  logic       frame_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      cyc = 0;
    end else begin
      cyc++;
      check("strobe", 32'(sym_strobe), 32'(((cyc - 1) % SPS) == 0));
      if (sym_strobe) begin
        slot_x   = {x0, x1, x2};
        slot_act = sym_active;
        slot_sym_q.push_back(slot_x);
        slot_act_q.push_back(slot_act);
        if (sym_active) act_sym_q.push_back(slot_x);
        else check("idle_x", 32'({x0, x1, x2}), 32'(0));
      end else begin
        check("hold", 32'({x0, x1, x2, sym_active}), 32'({slot_x, slot_act}));
      end
    end
  end

  // Expected payload-carrying slots of one frame: preamble, then the frame
  // bits cut into 5-bit symbols MSB first with the tail zero-filled.
  task automatic model_flush();
    int n;
    logic [4:0] s;
    n = frame_q.size();
    repeat (PRE_LEN) exp_q.push_back(PRE_SYM);
    for (int i = 0; i < n; i += 5) begin
      s = '0;
      for (int j = 0; j < 5; j++) if (i + j < n) s[4-j] = frame_q[i+j];
      exp_q.push_back(s);
    end
    frame_q.delete();
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, act_sym_q.size(), exp_q.size());
    n = (act_sym_q.size() < exp_q.size()) ? act_sym_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_sym%0d", tag, i), 32'(act_sym_q[i]), 32'(exp_q[i]));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bit   = 1'b0;
    rst      = 1'b0;
    slot_sym_q.delete();
    slot_act_q.delete();
    act_sym_q.delete();
    exp_q.delete();
    frame_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_x", 32'({x0, x1, x2}), 32'(0));
    check("rst_active", 32'(sym_active), 32'(0));
    check("rst_underrun", 32'(underrun), 32'(0));
    check("rst_strobe", 32'(sym_strobe), 32'(1));
    rst = 1'b1;
    check("rst_ready", 32'(in_ready), 32'(1));
  endtask

  task automatic wait_slots(input int n);
    repeat (n * SPS) @(posedge clk);
    #1;
  endtask

  // Called at #1 after a posedge; returns at #1 after the accepting edge.
  task automatic send_bit(input logic b, input logic l);
    logic ok;
    int waited;
    waited   = 0;
    ok       = 1'b0;
    in_bit   = b;
    in_last  = l;
    in_valid = 1'b1;
    while (!ok && waited < 500) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    check("accept", 32'(ok), 32'(1));
    in_valid = 1'b0;
    in_last  = 1'b0;
    frame_q.push_back(b);
  endtask

  task automatic send_frame(input int n, input logic [63:0] bits, input logic with_last,
                            input int gap_max);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) @(posedge clk);
      #0;
      send_bit(bits[n-1-i], with_last && (i == n - 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] first_sym;
    logic       rdy, dropped, done;
    int         acc, t, idx, seen;
    logic [63:0] rbits;

    rst = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_bit = 1'b0;
    @(posedge clk);
    #1;

    // Idle after reset: three idle slots in 30 clocks
    do_reset();
    repeat (30) @(posedge clk);
    #1;
    check("idle_slots", slot_sym_q.size(), 3);
    check("idle_active", act_sym_q.size(), 0);
    check("idle_underrun", 32'(underrun), 32'(0));

    // Two back-to-back frames: 1100110011 then 11100
    do_reset();
    send_frame(10, 64'b1100110011, 1'b1, 0);
    model_flush();
    send_frame(5, 64'b11100, 1'b1, 0);
    model_flush();
    wait_slots(16);
    compare_stream("b2b");
    if (act_sym_q.size() >= 6) begin
      check("b2b_d0", 32'(act_sym_q[4]), 32'(5'b11001));
      check("b2b_d1", 32'(act_sym_q[5]), 32'(5'b10011));
    end
    idx = -1;
    seen = 0;
    foreach (slot_act_q[i]) begin
      if (slot_act_q[i]) begin
        seen++;
        if (seen == 6) idx = i;
      end
    end
    check("b2b_found", 32'(idx >= 0 && idx + 2 < slot_act_q.size()), 32'(1));
    if (idx >= 0 && idx + 2 < slot_act_q.size()) begin
      check("b2b_gap", 32'(slot_act_q[idx+1]), 32'(0));
      check("b2b_pre", 32'(slot_act_q[idx+2]), 32'(1));
    end
    check("b2b_underrun", 32'(underrun), 32'(0));

    // Zero-filled tail: seven ones
    do_reset();
    send_frame(7, 64'b1111111, 1'b1, 0);
    model_flush();
    wait_slots(10);
    compare_stream("fill");
    if (act_sym_q.size() >= 6) begin
      check("fill_d0", 32'(act_sym_q[4]), 32'(5'b11111));
      check("fill_d1", 32'(act_sym_q[5]), 32'(5'b11000));
    end

    // Backpressure: continuous unlimited frame during the preamble
    do_reset();
    in_valid = 1'b1;
    in_last  = 1'b0;
    acc = 0;
    dropped = 1'b0;
    done = 1'b0;
    first_sym = '0;
    for (int k = 0; k < 200 && !done; k++) begin
      in_bit = 1'($urandom_range(0, 1));
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        if (acc < 5) first_sym[4-acc] = in_bit;
        acc++;
      end
      if (!dropped && !in_ready) begin
        dropped = 1'b1;
        check("bp_drop_bits", acc, 20);
      end else if (dropped && in_ready) begin
        done = 1'b1;
        check("bp_back_strobe", 32'(sym_strobe), 32'(1));
        check("bp_back_sym", 32'({x0, x1, x2}), 32'(first_sym));
        check("bp_back_active", 32'(sym_active), 32'(1));
      end
    end
    check("bp_back_seen", 32'(done), 32'(1));
    in_valid = 1'b0;

    // Underrun mid-frame, then the frame resumes
    do_reset();
    send_frame(5, 64'b10110, 1'b0, 0);
    wait_slots(9);
    check("ur_flag", 32'(underrun), 32'(1));
    check("ur_slots", 32'(slot_act_q.size() > 7), 32'(1));
    if (slot_act_q.size() > 7) begin
      check("ur_slot_act", 32'(slot_act_q[7]), 32'(0));
      check("ur_slot_sym", 32'(slot_sym_q[7]), 32'(0));
    end
    send_frame(5, 64'b01011, 1'b1, 0);
    model_flush();
    wait_slots(5);
    compare_stream("ur");
    check("ur_sticky", 32'(underrun), 32'(1));

    // Reset at counter 6 of a DATA slot
    do_reset();
    send_frame(15, 64'b101100111000111, 1'b0, 0);
    t = 0;
    while (act_sym_q.size() < 5 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("mr_reach_data", act_sym_q.size(), 5);
    repeat (4) @(posedge clk);
    #1;
    check("mr_pre_active", 32'(sym_active), 32'(1));
    rst = 1'b0;
    #1;
    check("mr_x", 32'({x0, x1, x2}), 32'(0));
    check("mr_active", 32'(sym_active), 32'(0));
    check("mr_strobe", 32'(sym_strobe), 32'(1));
    check("mr_ready", 32'(in_ready), 32'(1));
    do_reset();
    wait_slots(6);
    check("mr_no_payload", act_sym_q.size(), 0);
    check("mr_underrun", 32'(underrun), 32'(0));

    // Random frames with random input gaps against the model
    do_reset();
    for (int f = 0; f < 6; f++) begin
      rbits = {$urandom, $urandom};
      send_frame($urandom_range(1, 17), rbits, 1'b1, 2);
      model_flush();
    end
    wait_slots(70);
    compare_stream("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
